// File: rtl/la_pkg.sv
// Shared definitions for the logic analyzer capture path: trigger mode codes and FSM state encodings.
package la_pkg;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'b00,
    TRIG_RISING    = 2'b01,
    TRIG_FALLING   = 2'b10,
    TRIG_LEVEL     = 2'b11
  } trig_mode_e;

  typedef enum logic [2:0] {
    CAP_IDLE = 3'd0,
    CAP_PRE  = 3'd1,
    CAP_WAIT = 3'd2,
    CAP_POST = 3'd3,
    CAP_DONE = 3'd4
  } cap_state_e;

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample RAM: one write port, registered read port with a synchronous clear.
// Contents are never reset; only the read register is.
module la_sample_ram #(
  parameter int unsigned DEPTH = 160,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  input  logic             rclr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; rclr forces a zero word for out-of-window addresses
  always_ff @(posedge clk) begin
    if (reset || rclr) rdata <= '0;
    else               rdata <= mem[raddr];
  end

endmodule

// File: rtl/la_capture_engine.sv
// Triggered multi-channel capture engine for the logic analyzer.
// Prescaled sampling into a circular RAM, pre-trigger history, post-trigger fill, then freeze.
// Optional: define LA_INPUT_SYNC_EN to pass chan_in through a 2-flop synchronizer.
module la_capture_engine
  import la_pkg::*;
#(
  parameter int unsigned CHANNEL_COUNT  = 10,
  parameter int unsigned SAMPLE_DEPTH   = 160,
  parameter int unsigned PRESCALE_WIDTH = 16,
  localparam int unsigned AW = $clog2(SAMPLE_DEPTH),
  localparam int unsigned TW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNEL_COUNT-1:0]  chan_in,
  input  logic [CHANNEL_COUNT-1:0]  chan_enable,
  input  logic                      arm,
  input  logic [TW-1:0]             trig_channel,
  input  logic [1:0]                trig_mode,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [AW-1:0]             pretrig_count,
  input  logic [AW-1:0]             rd_addr,
  output logic [CHANNEL_COUNT-1:0]  rd_data,
  output logic [2:0]                cap_state,
  output logic                      done
);

  localparam int unsigned SELW = 1 << TW;
  localparam logic [AW-1:0] LAST = AW'(SAMPLE_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X = (AW+1)'(SAMPLE_DEPTH);

  cap_state_e               state;
  trig_mode_e               mode_q;
  logic [TW-1:0]            trig_ch_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] ps_cnt;
  logic [AW-1:0]            pretrig_q;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            pre_cnt;
  logic [AW-1:0]            post_cnt;
  logic [AW-1:0]            start_ptr;
  logic                     prev_valid;
  logic                     prev_bit;

  logic [CHANNEL_COUNT-1:0] chan_s;
  logic [CHANNEL_COUNT-1:0] sample_c;
  logic [SELW-1:0]          sel_ext_c;
  logic                     cur_bit_c;
  logic                     active_c;
  logic                     tick_c;
  logic                     wr_en_c;
  logic                     trig_hit_c;
  logic [AW-1:0]            wr_ptr_inc_c;
  logic [AW:0]              rd_sum_c;
  logic [AW-1:0]            rd_idx_c;
  logic                     rd_oob_c;

`ifdef LA_INPUT_SYNC_EN
  logic [CHANNEL_COUNT-1:0] sync1, sync2;

  // Two-flop synchronizer for asynchronous probe inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= chan_in;
      sync2 <= sync1;
    end
  end
  assign chan_s = sync2;
`else
  assign chan_s = chan_in;
`endif

  assign sample_c  = chan_s & chan_enable;
  assign sel_ext_c = SELW'(sample_c);
  assign cur_bit_c = sel_ext_c[trig_ch_q];
  assign active_c  = (state == CAP_PRE) || (state == CAP_WAIT) || (state == CAP_POST);
  assign tick_c    = active_c && (ps_cnt == prescale_q);
  // A POST entry with nothing left to fill must not overwrite the oldest sample
  assign wr_en_c   = tick_c && !arm && !((state == CAP_POST) && (post_cnt == '0));
  assign wr_ptr_inc_c = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);

  // Window index to physical RAM address
  assign rd_sum_c = {1'b0, start_ptr} + {1'b0, rd_addr};
  assign rd_idx_c = (rd_sum_c >= DEPTH_X) ? AW'(rd_sum_c - DEPTH_X) : AW'(rd_sum_c);
  assign rd_oob_c = ({1'b0, rd_addr} >= DEPTH_X);

  // Trigger condition on the sample being written this tick
  always_comb begin
    trig_hit_c = 1'b0;
    case (mode_q)
      TRIG_IMMEDIATE: trig_hit_c = 1'b1;
      TRIG_RISING:    trig_hit_c = prev_valid && !prev_bit && cur_bit_c;
      TRIG_FALLING:   trig_hit_c = prev_valid && prev_bit && !cur_bit_c;
      TRIG_LEVEL:     trig_hit_c = cur_bit_c;
      default:        trig_hit_c = 1'b0;
    endcase
  end

  // Capture FSM, prescaler, write pointer and trigger history
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CAP_IDLE;
      done       <= 1'b0;
      mode_q     <= TRIG_IMMEDIATE;
      trig_ch_q  <= '0;
      prescale_q <= '0;
      pretrig_q  <= '0;
      ps_cnt     <= '0;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      start_ptr  <= '0;
      prev_valid <= 1'b0;
      prev_bit   <= 1'b0;
    end else if (arm) begin
      mode_q     <= trig_mode_e'(trig_mode);
      trig_ch_q  <= trig_channel;
      prescale_q <= prescale;
      pretrig_q  <= pretrig_count;
      ps_cnt     <= '0;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      prev_valid <= 1'b0;
      prev_bit   <= 1'b0;
      done       <= 1'b0;
      state      <= (pretrig_count == '0) ? CAP_WAIT : CAP_PRE;
    end else begin
      if (active_c) ps_cnt <= tick_c ? '0 : ps_cnt + PRESCALE_WIDTH'(1);
      if (wr_en_c) begin
        wr_ptr     <= wr_ptr_inc_c;
        prev_bit   <= cur_bit_c;
        prev_valid <= 1'b1;
      end
      case (state)
        CAP_PRE: begin
          if (tick_c) begin
            pre_cnt <= pre_cnt + AW'(1);
            if (pre_cnt + AW'(1) == pretrig_q) state <= CAP_WAIT;
          end
        end
        CAP_WAIT: begin
          if (tick_c && trig_hit_c) begin
            state    <= CAP_POST;
            post_cnt <= LAST - pretrig_q;
          end
        end
        CAP_POST: begin
          if (post_cnt == '0) begin
            state     <= CAP_DONE;
            done      <= 1'b1;
            start_ptr <= wr_ptr;
          end else if (tick_c) begin
            post_cnt <= post_cnt - AW'(1);
            if (post_cnt == AW'(1)) begin
              state     <= CAP_DONE;
              done      <= 1'b1;
              start_ptr <= wr_ptr_inc_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cap_state = state;

  la_sample_ram #(
    .DEPTH (SAMPLE_DEPTH),
    .WIDTH (CHANNEL_COUNT),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en_c),
    .waddr (wr_ptr),
    .wdata (sample_c),
    .raddr (rd_idx_c),
    .rclr  (rd_oob_c),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed bench for la_capture_engine with CHANNEL_COUNT=4, SAMPLE_DEPTH=8.
// Expected window words are queued from the driven stimulus and popped as rd_data is read.
module tb_la_capture_engine;

  localparam int CC = 4;
  localparam int SD = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CC-1:0] chan_in;
  logic [CC-1:0] chan_enable;
  logic          arm;
  logic [1:0]    trig_channel;
  logic [1:0]    trig_mode;
  logic [PW-1:0] prescale;
  logic [2:0]    pretrig_count;
  logic [2:0]    rd_addr;
  logic [CC-1:0] rd_data;
  logic [2:0]    cap_state;
  logic          done;

  int n_eval = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];
  logic [3:0] hist[0:63];

  la_capture_engine #(
    .CHANNEL_COUNT  (CC),
    .SAMPLE_DEPTH   (SD),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .chan_in       (chan_in),
    .chan_enable   (chan_enable),
    .arm           (arm),
    .trig_channel  (trig_channel),
    .trig_mode     (trig_mode),
    .prescale      (prescale),
    .pretrig_count (pretrig_count),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .cap_state     (cap_state),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [1:0] ch,
                        input logic [PW-1:0] ps, input logic [2:0] pre);
    trig_mode     = mode;
    trig_channel  = ch;
    prescale      = ps;
    pretrig_count = pre;
    arm           = 1'b1;
    @(negedge clk);
    arm           = 1'b0;
  endtask

  // Drive one sample per clock until done (bounded); hist[t] holds the expected stored word
  task automatic run_capture(input int pat, input int limit, output int tt);
    logic [3:0] v;
    tt = 0;
    while (!done && tt < limit) begin
      tt++;
      case (pat)
        0:       v = 4'(tt + 5);
        1:       v = (4'(tt) & 4'hB) | ((tt >= 21) ? 4'h4 : 4'h0);
        2:       v = 4'(tt);
        default: v = 4'hF;
      endcase
      chan_in  = v;
      hist[tt] = v & chan_enable;
      @(negedge clk);
    end
  endtask

  task automatic read_window(input int first, input string tag);
    logic [3:0] e;
    for (int j = 0; j < SD; j++) begin
      exp_q.push_back(hist[first + j]);
      rd_addr = 3'(j);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, j), 32'(rd_data), 32'(e));
    end
  endtask

  initial begin
    int tt;
    int cnt;
    reset         = 1'b1;
    arm           = 1'b1;
    chan_in       = '0;
    chan_enable   = 4'hF;
    trig_channel  = '0;
    trig_mode     = 2'b00;
    prescale      = '0;
    pretrig_count = '0;
    rd_addr       = '0;

    // Reset held two clocks with arm asserted
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(cap_state), 32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_rdata", 32'(rd_data),   32'd0);
    reset = 1'b0;
    arm   = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(cap_state), 32'd0);

    // Immediate trigger, no pre-trigger, one tick per clock
    do_arm(2'b00, 2'd0, 16'd0, 3'd0);
    run_capture(0, 40, tt);
    check("imm_ticks", 32'(tt), 32'd8);
    check("imm_done",  32'(done), 32'd1);
    check("imm_state", 32'(cap_state), 32'd4);
    read_window(1, "imm_win");

    // Rising edge on ch2 after a long, wrapping WAIT; trigger inputs changed after arm
    do_arm(2'b01, 2'd2, 16'd0, 3'd3);
    trig_mode    = 2'b11;
    trig_channel = 2'd0;
    run_capture(1, 60, tt);
    check("rise_ticks", 32'(tt), 32'd25);
    read_window(18, "rise_win");
    rd_addr = 3'd3;
    @(negedge clk);
    check("rise_trig_bit", 32'(rd_data[2]), 32'd1);
    rd_addr = 3'd2;
    @(negedge clk);
    check("rise_pre_bit", 32'(rd_data[2]), 32'd0);

    // Prescale 2: write every third clock, done 24 clocks after arm
    do_arm(2'b00, 2'd0, 16'd2, 3'd0);
    cnt = 0;
    while (!done && cnt < 100) begin
      chan_in = 4'(cnt + 1);
      if ((cnt + 1) % 3 == 0) exp_q.push_back(4'(cnt + 1));
      @(negedge clk);
      cnt++;
    end
    check("ps_latency", 32'(cnt), 32'd24);
    for (int j = 0; j < SD; j++) begin
      logic [3:0] e;
      rd_addr = 3'(j);
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      check($sformatf("ps_win[%0d]", j), 32'(rd_data), 32'(e));
    end
    exp_q.delete();

    // Arm re-pulsed mid-POST: restart, window holds only new data
    do_arm(2'b00, 2'd0, 16'd0, 3'd0);
    chan_in = 4'hA;
    repeat (4) @(negedge clk);
    check("rst_mid_state", 32'(cap_state), 32'd3);
    check("rst_mid_done",  32'(done),      32'd0);
    do_arm(2'b00, 2'd0, 16'd0, 3'd0);
    run_capture(2, 40, tt);
    check("restart_ticks", 32'(tt), 32'd8);
    read_window(1, "restart_win");

    // Maximum pre-trigger: POST entered with nothing left to fill
    do_arm(2'b00, 2'd0, 16'd0, 3'd7);
    run_capture(2, 40, tt);
    check("maxpre_ticks", 32'(tt), 32'd9);
    check("maxpre_state", 32'(cap_state), 32'd4);
    read_window(1, "maxpre_win");

    // Disabled channel: level trigger on ch2 never fires
    chan_enable = 4'b1011;
    chan_in     = 4'hF;
    do_arm(2'b11, 2'd2, 16'd0, 3'd0);
    repeat (20) @(negedge clk);
    check("dis_state", 32'(cap_state), 32'd2);
    check("dis_done",  32'(done),      32'd0);

    // Disabled channel stored as zero
    do_arm(2'b00, 2'd0, 16'd0, 3'd0);
    run_capture(3, 40, tt);
    check("mask_ticks", 32'(tt), 32'd8);
    read_window(1, "mask_win");
    rd_addr = 3'd5;
    @(negedge clk);
    check("mask_word", 32'(rd_data), 32'hB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
